// File: rtl/byte_serializer_pkg.sv
// Shared constants and state type for the byte serializer.
package byte_serializer_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned CNT_W     = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/byte_serializer_if.sv
// Word-in / byte-out valid-ready bundle between upstream, serializer and sink.
interface byte_serializer_if #(
    parameter int unsigned W     = byte_serializer_pkg::BYTE_W,
    parameter int unsigned IDX_W = byte_serializer_pkg::IDX_W
);

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_b1;
    logic [W-1:0]     in_b2;
    logic [W-1:0]     in_b3;
    logic [W-1:0]     in_b4;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    modport master (
        output in_valid, in_b1, in_b2, in_b3, in_b4, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_b1, in_b2, in_b3, in_b4, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/byte_serializer.sv
// Accepts one word of four byte lanes and emits it one byte per cycle with
// index/last tags; a new word can be taken on the last-byte handshake.
module byte_serializer
    import byte_serializer_pkg::*;
#(
    parameter int unsigned W         = BYTE_W,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    byte_serializer_if.slave    bus,
    output logic                busy,
    output logic [CNT_W-1:0]    word_cnt
);

    state_t           state_q, state_d;
    logic [W-1:0]     sr_q [NUM_LANES];
    logic [W-1:0]     sr_d [NUM_LANES];
    logic [W-1:0]     lane [NUM_LANES];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q;
    logic             is_last;
    logic             in_fire;
    logic             out_fire;
    logic             last_fire;

    assign lane[0] = bus.in_b1;
    assign lane[1] = bus.in_b2;
    assign lane[2] = bus.in_b3;
    assign lane[3] = bus.in_b4;

    assign busy          = (state_q == ST_SEND);
    assign is_last       = busy && (idx_q == IDX_W'(NUM_LANES - 1));
    assign bus.out_valid = busy;
    assign bus.out_last  = is_last;
    assign bus.out_idx   = idx_q;
    assign bus.out_data  = busy ? sr_q[0] : '0;
    // Ready on the last-byte handshake lets words stream with no idle cycle.
    assign bus.in_ready  = (state_q == ST_IDLE) || (is_last && bus.out_ready);

    assign in_fire   = bus.in_valid && bus.in_ready;
    assign out_fire  = busy && bus.out_ready;
    assign last_fire = is_last && bus.out_ready;
    assign word_cnt  = cnt_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        unique case (state_q)
            ST_IDLE: if (in_fire) state_d = ST_SEND;
            ST_SEND: if (last_fire && !in_fire) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Lane order is fixed at load, so the register only ever shifts toward slot 0.
        if (in_fire) begin
            idx_d = '0;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                sr_d[i] = MSB_FIRST ? lane[i] : lane[NUM_LANES - 1 - i];
            end
        end else if (out_fire) begin
            idx_d = idx_q + 1'b1;
            for (int unsigned i = 0; i < NUM_LANES - 1; i++) begin
                sr_d[i] = sr_q[i + 1];
            end
            sr_d[NUM_LANES - 1] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            if (last_fire) cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench: MSB-first and LSB-first serializers driven in parallel,
// checked against a byte-queue reference model.
module tb_byte_serializer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  b1, b2, b3, b4;
    logic        busy0, busy1;
    logic [15:0] cnt0, cnt1;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    byte_serializer_if bus0 ();
    byte_serializer_if bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.out_ready = out_ready;
    assign bus0.in_b1     = b1;
    assign bus0.in_b2     = b2;
    assign bus0.in_b3     = b3;
    assign bus0.in_b4     = b4;
    assign bus1.in_valid  = in_valid;
    assign bus1.out_ready = out_ready;
    assign bus1.in_b1     = b1;
    assign bus1.in_b2     = b2;
    assign bus1.in_b3     = b3;
    assign bus1.in_b4     = b4;

    byte_serializer #(.MSB_FIRST(1'b1)) u0 (
        .clk(clk), .reset(reset), .bus(bus0.slave), .busy(busy0), .word_cnt(cnt0)
    );
    byte_serializer #(.MSB_FIRST(1'b0)) u1 (
        .clk(clk), .reset(reset), .bus(bus1.slave), .busy(busy1), .word_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bytes still owed for the held word, in emission order.
    logic [7:0]  q0 [$];
    logic [7:0]  q1 [$];
    logic [15:0] mcnt;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic [7:0] data_lsb;
        logic [1:0] idx;
        logic       last;
        logic       in_ready;
    } exp_t;

    function automatic exp_t model_exp();
        exp_t e;
        e.valid    = (q0.size() != 0);
        e.data     = e.valid ? q0[0] : 8'h00;
        e.data_lsb = e.valid ? q1[0] : 8'h00;
        e.idx      = e.valid ? 2'(4 - q0.size()) : 2'd0;
        e.last     = (q0.size() == 1);
        e.in_ready = (q0.size() == 0) || ((q0.size() == 1) && out_ready);
        return e;
    endfunction

    task automatic tick();
        exp_t e;
        e = model_exp();
        if (reset) begin
            q0.delete();
            q1.delete();
            mcnt = 16'h0000;
        end else begin
            if (e.valid && out_ready) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
                if (q0.size() == 0) mcnt = mcnt + 16'h0001;
            end
            if (in_valid && e.in_ready) begin
                q0.push_back(b1); q0.push_back(b2); q0.push_back(b3); q0.push_back(b4);
                q1.push_back(b4); q1.push_back(b3); q1.push_back(b2); q1.push_back(b1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input logic [31:0] w);
        b1 = w[31:24];
        b2 = w[23:16];
        b3 = w[15:8];
        b4 = w[7:0];
    endtask

    task automatic test_reset();
        logic [29:0] got, want;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; set_word(32'h0);
        tick(); tick();
        reset = 1'b0;
        #1;
        got  = {bus0.out_valid, bus0.out_data, bus0.out_idx, bus0.out_last, busy0, cnt0, bus0.in_ready};
        want = {1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b1};
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", got, want);
        end
        n_chk++;
        if (bus1.in_ready !== 1'b1 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_lsb: in_ready %b busy %b want 1 0", bus1.in_ready, busy1);
        end
        n_chk++;
    endtask

    task automatic test_single_word();
        logic [7:0] seq [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        set_word(32'h12345678); in_valid = 1'b1; out_ready = 1'b1;
        #1;
        if (bus0.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_in_ready: got %b want 1", bus0.in_ready);
        end
        n_chk++;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_word($urandom);
            #1;
            if ({bus0.out_valid, bus0.out_data, bus0.out_idx, bus0.out_last} !==
                {1'b1, seq[i], 2'(i), (i == 3)}) begin
                n_fail++;
                $display("FAIL single_byte%0d: got v%b d%h i%0d l%b want d%h i%0d", i,
                         bus0.out_valid, bus0.out_data, bus0.out_idx, bus0.out_last, seq[i], i);
            end
            n_chk++;
            tick();
        end
        #1;
        if (cnt0 !== 16'd1 || bus0.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: word_cnt %h valid %b want 0001 0", cnt0, bus0.out_valid);
        end
        n_chk++;
    endtask

    task automatic test_lsb_first();
        logic [7:0] seq [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        set_word(32'h12345678); in_valid = 1'b1; out_ready = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus1.out_data !== seq[i] || bus1.out_idx !== 2'(i)) begin
                n_fail++;
                $display("FAIL lsb_byte%0d: got d%h i%0d want d%h i%0d", i,
                         bus1.out_data, bus1.out_idx, seq[i], i);
            end
            n_chk++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  seq [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
        logic [15:0] cnt_before;
        cnt_before = mcnt;
        set_word(32'hAABBCCDD); in_valid = 1'b1; out_ready = 1'b1;
        #1;
        tick();
        set_word(32'h01020304);
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus0.out_valid !== 1'b1 || bus0.out_data !== seq[i]) begin
                n_fail++;
                $display("FAIL b2b_byte%0d: got v%b d%h want v1 d%h", i,
                         bus0.out_valid, bus0.out_data, seq[i]);
            end
            n_chk++;
            if (i == 3) begin
                if (bus0.in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_in_ready_dd: got %b want 1", bus0.in_ready);
                end
                n_chk++;
            end
            tick();
            if (i == 3) in_valid = 1'b0;
        end
        #1;
        if (cnt0 !== cnt_before + 16'd2 || bus0.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done: word_cnt %h valid %b want %h 0", cnt0, bus0.out_valid,
                     cnt_before + 16'd2);
        end
        n_chk++;
    endtask

    task automatic test_stall();
        logic [7:0] seq [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        set_word(32'h12345678); in_valid = 1'b1; out_ready = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        #1;
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_word($urandom);
            #1;
            if ({bus0.out_valid, bus0.out_data, bus0.out_idx, bus0.out_last} !==
                {1'b1, 8'h34, 2'd1, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v%b d%h i%0d l%b want v1 d34 i1 l0", k,
                         bus0.out_valid, bus0.out_data, bus0.out_idx, bus0.out_last);
            end
            n_chk++;
            tick();
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            set_word($urandom);
            #1;
            if (bus0.out_data !== seq[i] || bus0.out_idx !== 2'(i)) begin
                n_fail++;
                $display("FAIL stall_resume%0d: got d%h i%0d want d%h i%0d", i,
                         bus0.out_data, bus0.out_idx, seq[i], i);
            end
            n_chk++;
            tick();
        end
    endtask

    task automatic test_random();
        exp_t        e;
        logic [51:0] got, want;
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            set_word($urandom);
            #1;
            e = model_exp();
            got  = {bus0.out_valid, bus0.out_data, bus1.out_data, bus0.out_idx, bus0.out_last,
                    bus0.in_ready, busy0, cnt0, bus1.out_idx, bus1.out_last, bus1.in_ready,
                    busy1, cnt1[3:0]};
            want = {e.valid, e.data, e.data_lsb, e.idx, e.last, e.in_ready, e.valid, mcnt,
                    e.idx, e.last, e.in_ready, e.valid, mcnt[3:0]};
            if (got !== want) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got %h want %h", c, got, want);
            end
            n_chk++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            #1;
            tick();
        end
    endtask

    task automatic test_wrap();
        force u0.cnt_q = 16'hFFFF;
        mcnt = 16'hFFFF;
        #1;
        release u0.cnt_q;
        #1;
        if (cnt0 !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_preload: got %h want ffff", cnt0);
        end
        n_chk++;
        set_word(32'h12345678); in_valid = 1'b1; out_ready = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        repeat (4) begin
            #1;
            tick();
        end
        #1;
        if (cnt0 !== 16'h0000 || cnt0 !== mcnt) begin
            n_fail++;
            $display("FAIL wrap_count: got %h want 0000", cnt0);
        end
        n_chk++;
    endtask

    task automatic test_reset_mid_word();
        logic [28:0] got, want;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_word(32'h12345678); in_valid = 1'b1; out_ready = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        #1;
        tick();
        #1;
        if (bus0.out_data !== 8'h34) begin
            n_fail++;
            $display("FAIL midrst_pre: got %h want 34", bus0.out_data);
        end
        n_chk++;
        tick();
        reset = 1'b1;
        #1;
        tick();
        reset = 1'b0;
        #1;
        got  = {bus0.out_valid, busy0, cnt0, bus0.in_ready, bus0.out_data, bus0.out_last};
        want = {1'b0, 1'b0, mcnt, 1'b1, 8'h00, 1'b0};
        if (got !== want || cnt0 !== 16'h0000) begin
            n_fail++;
            $display("FAIL midrst_state: got %h want %h", got, want);
        end
        n_chk++;
    endtask

    initial begin
        mcnt = 16'h0000;
        test_reset();
        test_single_word();
        test_lsb_first();
        test_back_to_back();
        test_stall();
        test_random();
        test_wrap();
        test_reset_mid_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
